// File: rtl/vrf_pkg.sv
// Shared constants and the lane-merge helper for the masked vector register file.
// lane_merge works on the widest supported vector; callers zero-extend their
// operands and truncate the result back to their own vector width.
package vrf_pkg;

  localparam int unsigned VRF_NUM_REGS = 8;
  localparam int unsigned VRF_LANES    = 16;
  localparam int unsigned VRF_ELEM_W   = 16;

  // Upper bounds accepted by lane_merge (LANES <= 128, LANES*ELEM_W <= 2048).
  localparam int unsigned VRF_MAX_LANES  = 128;
  localparam int unsigned VRF_MAX_VEC_W  = 2048;
  localparam int unsigned VRF_LANE_IDX_W = $clog2(VRF_MAX_LANES);
  localparam int unsigned VRF_BIT_IDX_W  = $clog2(VRF_MAX_VEC_W);

  // Bit b comes from new_vec when the lane that owns it (b / elem_w) is masked in,
  // otherwise from old_vec. elem_w must be non-zero.
  function automatic logic [VRF_MAX_VEC_W-1:0] lane_merge(
    input logic [VRF_MAX_VEC_W-1:0] old_vec,
    input logic [VRF_MAX_VEC_W-1:0] new_vec,
    input logic [VRF_MAX_LANES-1:0] mask,
    input int unsigned              elem_w
  );
    logic [VRF_MAX_VEC_W-1:0] res;
    int unsigned              lane;
    res = old_vec;
    for (int unsigned b = 0; b < VRF_MAX_VEC_W; b++) begin
      lane = b / elem_w;
      if (lane < VRF_MAX_LANES) begin
        if (mask[lane[VRF_LANE_IDX_W-1:0]]) begin
          res[b[VRF_BIT_IDX_W-1:0]] = new_vec[b[VRF_BIT_IDX_W-1:0]];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vec_regfile_masked_if.sv
// Bus bundle of the masked vector register file.
//   read   : rd_addr_a/b in, rd_data_a/b and rd_hazard_a/b out
//   write  : wr_en, wr_dst, wr_lane_mask, wr_data in
//   reserve: rsv_en, rsv_dst in, pending and rsv_err out
// master = issue/writeback side, slave = the register file.
interface vec_regfile_masked_if
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = VRF_NUM_REGS,
  parameter int unsigned LANES    = VRF_LANES,
  parameter int unsigned ELEM_W   = VRF_ELEM_W,
  localparam int unsigned VEC_W   = LANES * ELEM_W,
  localparam int unsigned ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);

  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [VEC_W-1:0]    rd_data_a;
  logic [VEC_W-1:0]    rd_data_b;
  logic                rd_hazard_a;
  logic                rd_hazard_b;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_dst;
  logic [LANES-1:0]    wr_lane_mask;
  logic [VEC_W-1:0]    wr_data;
  logic                rsv_en;
  logic [ADDR_W-1:0]   rsv_dst;
  logic [NUM_REGS-1:0] pending;
  logic                rsv_err;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_dst, wr_lane_mask, wr_data, rsv_en, rsv_dst,
    input  rd_data_a, rd_data_b, rd_hazard_a, rd_hazard_b, pending, rsv_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_dst, wr_lane_mask, wr_data, rsv_en, rsv_dst,
    output rd_data_a, rd_data_b, rd_hazard_a, rd_hazard_b, pending, rsv_err
  );

endinterface

// File: rtl/vrf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation, cleared by
// a write. Also produces the one-cycle rsv_err pulse and the registered hazard
// flags that accompany each read port.
// Ports: clk, rst_n (async, active low); wr_en/wr_dst, rsv_en/rsv_dst in;
// rd_addr_a/b in; pending, rsv_err, rd_hazard_a/b out (all registered).
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = VRF_NUM_REGS,
  localparam int unsigned ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_dst,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_dst,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [NUM_REGS-1:0] pending,
  output logic                rsv_err,
  output logic                rd_hazard_a,
  output logic                rd_hazard_b
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                rsv_err_q, rsv_err_d;
  logic                hazard_a_q, hazard_a_d;
  logic                hazard_b_q, hazard_b_d;
  logic                wr_ok, rsv_ok, rd_a_ok, rd_b_ok;

  always_comb begin
    wr_ok   = wr_en && (32'(wr_dst) < NUM_REGS);
    rsv_ok  = rsv_en && (32'(rsv_dst) < NUM_REGS);
    rd_a_ok = 32'(rd_addr_a) < NUM_REGS;
    rd_b_ok = 32'(rd_addr_b) < NUM_REGS;

    // Retire before reserve, so a same-register write+reserve leaves the bit set.
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[wr_dst] = 1'b0;
    end
    if (rsv_ok) begin
      pending_d[rsv_dst] = 1'b1;
    end

    rsv_err_d = 1'b0;
    if (rsv_ok && pending_q[rsv_dst] && !(wr_ok && (wr_dst == rsv_dst))) begin
      rsv_err_d = 1'b1;
    end

    // Hazard follows the post-edge scoreboard so it matches bypassed read data.
    hazard_a_d = 1'b0;
    hazard_b_d = 1'b0;
    if (rd_a_ok) begin
      hazard_a_d = pending_d[rd_addr_a];
    end
    if (rd_b_ok) begin
      hazard_b_d = pending_d[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rsv_err_q  <= 1'b0;
      hazard_a_q <= 1'b0;
      hazard_b_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rsv_err_q  <= rsv_err_d;
      hazard_a_q <= hazard_a_d;
      hazard_b_q <= hazard_b_d;
    end
  end

  assign pending     = pending_q;
  assign rsv_err     = rsv_err_q;
  assign rd_hazard_a = hazard_a_q;
  assign rd_hazard_b = hazard_b_q;

endmodule

// File: rtl/vec_regfile_masked.sv
// Parametrised multi-lane vector register file with per-lane write masking,
// write-first read bypass on both read ports and a pending-write scoreboard.
// Ports: clk, rst_n (async, active low), bus (vec_regfile_masked_if.slave):
// two registered read ports with hazard flags, one masked write port and a
// reservation port with pending/rsv_err status.
module vec_regfile_masked
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = VRF_NUM_REGS,
  parameter int unsigned LANES    = VRF_LANES,
  parameter int unsigned ELEM_W   = VRF_ELEM_W,
  localparam int unsigned VEC_W   = LANES * ELEM_W,
  localparam int unsigned ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input logic                  clk,
  input logic                  rst_n,
  vec_regfile_masked_if.slave  bus
);

  logic [VEC_W-1:0] mem_q [NUM_REGS];
  logic [VEC_W-1:0] wr_merged;
  logic [VEC_W-1:0] rd_data_a_d, rd_data_a_q;
  logic [VEC_W-1:0] rd_data_b_d, rd_data_b_q;
  logic             wr_ok, rd_a_ok, rd_b_ok;

  function automatic logic [VEC_W-1:0] merge(
    input logic [VEC_W-1:0] old_vec,
    input logic [VEC_W-1:0] new_vec,
    input logic [LANES-1:0] mask
  );
    return VEC_W'(lane_merge(VRF_MAX_VEC_W'(old_vec), VRF_MAX_VEC_W'(new_vec),
                             VRF_MAX_LANES'(mask), ELEM_W));
  endfunction

  always_comb begin
    wr_ok   = bus.wr_en && (32'(bus.wr_dst) < NUM_REGS);
    rd_a_ok = 32'(bus.rd_addr_a) < NUM_REGS;
    rd_b_ok = 32'(bus.rd_addr_b) < NUM_REGS;

    wr_merged = '0;
    if (wr_ok) begin
      wr_merged = merge(mem_q[bus.wr_dst], bus.wr_data, bus.wr_lane_mask);
    end

    // The merged write value is exactly what a write-first read must see.
    rd_data_a_d = '0;
    if (wr_ok && (bus.rd_addr_a == bus.wr_dst)) begin
      rd_data_a_d = wr_merged;
    end else if (rd_a_ok) begin
      rd_data_a_d = mem_q[bus.rd_addr_a];
    end

    rd_data_b_d = '0;
    if (wr_ok && (bus.rd_addr_b == bus.wr_dst)) begin
      rd_data_b_d = wr_merged;
    end else if (rd_b_ok) begin
      rd_data_b_d = mem_q[bus.rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_ok) begin
      mem_q[bus.wr_dst] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;

  vrf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.wr_en),
    .wr_dst      (bus.wr_dst),
    .rsv_en      (bus.rsv_en),
    .rsv_dst     (bus.rsv_dst),
    .rd_addr_a   (bus.rd_addr_a),
    .rd_addr_b   (bus.rd_addr_b),
    .pending     (bus.pending),
    .rsv_err     (bus.rsv_err),
    .rd_hazard_a (bus.rd_hazard_a),
    .rd_hazard_b (bus.rd_hazard_b)
  );

endmodule

// File: tb/tb_vec_regfile_masked.sv
// Drives an 8-register and a 6-register instance with identical stimulus and
// checks both against a lane-level reference model.
module tb_vec_regfile_masked;

  typedef logic [255:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  rd_a, rd_b, wdst, rdst;
  logic        wen, ren;
  logic [15:0] wmask;
  vec_t        wdata;

  vec_regfile_masked_if #(.NUM_REGS(8), .LANES(16), .ELEM_W(16)) if8 ();
  vec_regfile_masked_if #(.NUM_REGS(6), .LANES(16), .ELEM_W(16)) if6 ();

  vec_regfile_masked #(.NUM_REGS(8), .LANES(16), .ELEM_W(16)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );
  vec_regfile_masked #(.NUM_REGS(6), .LANES(16), .ELEM_W(16)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6)
  );

  assign if8.rd_addr_a = rd_a;   assign if6.rd_addr_a = rd_a;
  assign if8.rd_addr_b = rd_b;   assign if6.rd_addr_b = rd_b;
  assign if8.wr_en = wen;        assign if6.wr_en = wen;
  assign if8.wr_dst = wdst;      assign if6.wr_dst = wdst;
  assign if8.wr_lane_mask = wmask; assign if6.wr_lane_mask = wmask;
  assign if8.wr_data = wdata;    assign if6.wr_data = wdata;
  assign if8.rsv_en = ren;       assign if6.rsv_en = ren;
  assign if8.rsv_dst = rdst;     assign if6.rsv_dst = rdst;

  vec_t       o_rda[2], o_rdb[2];
  logic       o_ha[2], o_hb[2], o_err[2];
  logic [7:0] o_pend[2];
  assign o_rda[0] = if8.rd_data_a;   assign o_rda[1] = if6.rd_data_a;
  assign o_rdb[0] = if8.rd_data_b;   assign o_rdb[1] = if6.rd_data_b;
  assign o_ha[0] = if8.rd_hazard_a;  assign o_ha[1] = if6.rd_hazard_a;
  assign o_hb[0] = if8.rd_hazard_b;  assign o_hb[1] = if6.rd_hazard_b;
  assign o_err[0] = if8.rsv_err;     assign o_err[1] = if6.rsv_err;
  assign o_pend[0] = if8.pending;    assign o_pend[1] = {2'b00, if6.pending};

  // Reference model state, one copy per instance.
  int         nregs[2];
  vec_t       m_mem[2][8];
  logic [7:0] m_pend[2];
  vec_t       e_rda[2], e_rdb[2];
  logic       e_ha[2], e_hb[2], e_err[2];

  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t lane_write(vec_t old_v, vec_t new_v, logic [15:0] m);
    vec_t r = old_v;
    for (int l = 0; l < 16; l++) begin
      if (m[l]) r[l*16 +: 16] = new_v[l*16 +: 16];
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) m_mem[d][r] = '0;
      m_pend[d] = '0;
      e_rda[d] = '0; e_rdb[d] = '0;
      e_ha[d] = 1'b0; e_hb[d] = 1'b0; e_err[d] = 1'b0;
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit         wok, rok, aok, bok;
      vec_t       wval;
      logic [7:0] np;
      wok = wen && (int'(wdst) < nregs[d]);
      rok = ren && (int'(rdst) < nregs[d]);
      aok = int'(rd_a) < nregs[d];
      bok = int'(rd_b) < nregs[d];
      wval = wok ? lane_write(m_mem[d][wdst], wdata, wmask) : '0;
      e_rda[d] = !aok ? '0 : (wok && wdst == rd_a) ? wval : m_mem[d][rd_a];
      e_rdb[d] = !bok ? '0 : (wok && wdst == rd_b) ? wval : m_mem[d][rd_b];
      np = m_pend[d];
      if (wok) np[wdst] = 1'b0;
      if (rok) np[rdst] = 1'b1;
      e_err[d] = rok && m_pend[d][rdst] && !(wok && wdst == rdst);
      e_ha[d] = aok ? np[rd_a] : 1'b0;
      e_hb[d] = bok ? np[rd_b] : 1'b0;
      if (wok) m_mem[d][wdst] = wval;
      m_pend[d] = np;
    end
  endtask

  task automatic chk(input string tag, input int d, input vec_t obs, input vec_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, (d == 0) ? 8 : 6, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, ".rd_data_a"}, d, o_rda[d], e_rda[d]);
      chk({tag, ".rd_data_b"}, d, o_rdb[d], e_rdb[d]);
      chk({tag, ".rd_hazard_a"}, d, vec_t'(o_ha[d]), vec_t'(e_ha[d]));
      chk({tag, ".rd_hazard_b"}, d, vec_t'(o_hb[d]), vec_t'(e_hb[d]));
      chk({tag, ".pending"}, d, vec_t'(o_pend[d]), vec_t'(m_pend[d]));
      chk({tag, ".rsv_err"}, d, vec_t'(o_err[d]), vec_t'(e_err[d]));
    end
  endtask

  task automatic idle();
    rd_a = '0; rd_b = '0; wen = 1'b0; wdst = '0; wmask = '0; wdata = '0;
    ren = 1'b0; rdst = '0;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    nregs[0] = 8;
    nregs[1] = 6;
    idle();
    model_reset();

    // Asynchronous reset, then read every register on both ports.
    #2 rst_n = 1'b0;
    #1 check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_hold");
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      rd_a = r[2:0];
      rd_b = 3'(7 - r);
      step("reset_read");
    end

    // Full write of reg3 followed by a lanes 4-7 overwrite.
    idle();
    wen = 1'b1; wdst = 3'd3; wmask = 16'hFFFF; wdata = {4{64'h0123456789ABCDEF}};
    step("wr3_full");
    wdata = '1; wmask = 16'h00F0;
    step("wr3_part");
    idle(); rd_a = 3'd3; rd_b = 3'd3;
    step("rd3");
    chk("rd3_lanes", 0, o_rda[0],
        256'h0123456789ABCDEF_0123456789ABCDEF_FFFFFFFFFFFFFFFF_0123456789ABCDEF);

    // Same-edge masked write to reg5 bypassed to port A; port B reads reg2.
    idle(); wen = 1'b1; wmask = 16'hFFFF;
    wdst = 3'd2; wdata = rand_vec(); step("wr2");
    wdst = 3'd5; wdata = rand_vec(); step("wr5");
    wdst = 3'd5; wmask = 16'h000F; wdata = {16{16'hAAAA}}; rd_a = 3'd5; rd_b = 3'd2;
    step("bypass");
    chk("bypass_lo", 0, vec_t'(o_rda[0][63:0]), vec_t'({4{16'hAAAA}}));

    // Reserve reg1, observe hazard, retire with an all-zero-mask write.
    idle(); ren = 1'b1; rdst = 3'd1; rd_a = 3'd1;
    step("rsv1");
    idle(); rd_a = 3'd1;
    step("rd1_hazard");
    chk("pend_02", 0, vec_t'(o_pend[0]), vec_t'(8'h02));
    wen = 1'b1; wdst = 3'd1; wmask = 16'h0000; wdata = rand_vec();
    step("wr1_nomask");
    idle(); rd_a = 3'd1;
    step("rd1_clear");

    // Double reservation of reg6, then write+reserve on the same edge.
    idle(); ren = 1'b1; rdst = 3'd6; rd_b = 3'd6;
    step("rsv6_first");
    step("rsv6_second");
    chk("rsv6_err", 0, vec_t'(o_err[0]), vec_t'(1'b1));
    idle(); rd_b = 3'd6;
    step("rsv6_err_drop");
    wen = 1'b1; wdst = 3'd6; wmask = 16'h00FF; wdata = rand_vec(); ren = 1'b1; rdst = 3'd6;
    step("wr_rsv6");
    chk("wr_rsv6_err", 0, vec_t'(o_err[0]), vec_t'(1'b0));

    // Index 7: out of range for the 6-register instance.
    idle(); wen = 1'b1; wdst = 3'd7; wmask = 16'hFFFF; wdata = rand_vec();
    ren = 1'b1; rdst = 3'd7; rd_a = 3'd7; rd_b = 3'd7;
    step("idx7_wr_rsv");
    wen = 1'b0;
    step("idx7_rsv_again");
    idle(); rd_a = 3'd7;
    step("idx7_rd");
    chk("idx7_rd6", 1, o_rda[1], '0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      wen = ($urandom_range(0, 2) != 0);
      wdst = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: wmask = 16'h0000;
        1: wmask = 16'hFFFF;
        default: wmask = 16'($urandom());
      endcase
      wdata = rand_vec();
      ren = ($urandom_range(0, 2) == 0);
      rdst = 3'($urandom_range(0, 7));
      rd_a = ($urandom_range(0, 3) == 0) ? wdst : 3'($urandom_range(0, 7));
      rd_b = ($urandom_range(0, 3) == 0) ? wdst : 3'($urandom_range(0, 7));
      step("random");
    end

    // Reset asserted mid-write: outputs clear at once and the write is lost.
    idle(); wen = 1'b1; wdst = 3'd4; wmask = 16'hFFFF; wdata = rand_vec(); rd_a = 3'd4;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    @(posedge clk); #1;
    check_all("rst_mid_hold");
    rst_n = 1'b1;
    idle(); rd_a = 3'd4;
    step("rd4_after_rst");
    chk("rd4_zero", 0, o_rda[0], '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
